// File: rtl/bfs_dc_resp_if.sv
// Request/response and memory-port signals between bfs_core, bfs_dc_resp and the L2 port.
// slave: the responder; master: the core plus memory side around it.
interface bfs_dc_resp_if;
  logic        bfs_dc_req;
  logic [31:0] bfs_dc_addr;
  logic        dc_ready;
  logic        dc_rbuf_empty;
  logic        dc_valid;
  logic [63:0] dc_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_valid;
  logic [63:0] mem_rdata;

  modport slave (
    input  bfs_dc_req, bfs_dc_addr, mem_ready, mem_valid, mem_rdata,
    output dc_ready, dc_rbuf_empty, dc_valid, dc_rdata, mem_req, mem_addr
  );

  modport master (
    output bfs_dc_req, bfs_dc_addr, mem_ready, mem_valid, mem_rdata,
    input  dc_ready, dc_rbuf_empty, dc_valid, dc_rdata, mem_req, mem_addr
  );
endinterface

// File: rtl/bfs_dc_resp.sv
// BFS data-cache responder: queues read requests, fetches one line per request and replays it
// as a gap-free BEATS-cycle frame. Define BFS_DC_RESP_STATS_EN to add request/stall counters.
module bfs_dc_resp #(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned BEATS  = 8
) (
  input  logic         clk,
  input  logic         rst,
  bfs_dc_resp_if.slave bus
`ifdef BFS_DC_RESP_STATS_EN
  ,
  output logic [31:0]  stat_reqs,
  output logic [31:0]  stat_stalls
`endif
);

  localparam int unsigned    AW        = $clog2(QDEPTH);
  localparam int unsigned    BW        = $clog2(BEATS);
  localparam logic [AW:0]    FULL_CNT  = (AW+1)'(QDEPTH);
  localparam logic [BW-1:0]  LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MREQ,
    FILL,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  // Request FIFO
  logic [31:0]   fifo_mem [QDEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  logic [31:0]   head;

  // Line buffer
  logic [63:0]   line [BEATS];
  logic [BW-1:0] wcnt, rcnt;

  // Readiness depends on occupancy alone, so a pop never opens a slot in the same cycle.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = bus.bfs_dc_req & ~full;
  assign head  = fifo_mem[rptr];

  assign bus.dc_ready      = ~full;
  assign bus.dc_rbuf_empty = (state_q == IDLE) & empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= bus.bfs_dc_addr;
  end

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;
    bus.dc_valid = 1'b0;
    bus.dc_rdata = '0;
    case (state_q)
      IDLE: begin
        if (!empty) state_d = MREQ;
      end
      MREQ: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = head & 32'hFFFF_FFF8;
        if (bus.mem_ready) begin
          pop     = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (bus.mem_valid && (wcnt == LAST_BEAT)) state_d = DRAIN;
      end
      DRAIN: begin
        bus.dc_valid = 1'b1;
        bus.dc_rdata = line[rcnt];
        if (rcnt == LAST_BEAT) state_d = empty ? IDLE : MREQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt    <= '0;
      rcnt    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == MREQ && bus.mem_ready)
        wcnt <= '0;
      else if (state_q == FILL && bus.mem_valid)
        wcnt <= wcnt + BW'(1);
      if (state_q == DRAIN)
        rcnt <= (rcnt == LAST_BEAT) ? '0 : rcnt + BW'(1);
    end
  end

  // Beats arriving outside FILL are dropped here.
  always_ff @(posedge clk) begin
    if (state_q == FILL && bus.mem_valid) line[wcnt] <= bus.mem_rdata;
  end

`ifdef BFS_DC_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_reqs   <= '0;
      stat_stalls <= '0;
    end else begin
      if (push) stat_reqs <= stat_reqs + 32'd1;
      if (state_q == MREQ && !bus.mem_ready) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule
